// File: rtl/frame_buffer_writer.sv
// Ping-pong frame buffer write side: takes RGB pixels over valid/ready
// and writes them as R,G,B bytes into whichever buffer is granted.
module frame_buffer_writer #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              CSDisplay,
   input  logic [9:0]        AIPIn,
   input  logic [9:0]        AILIn,
   input  logic [23:0]       PixIn,
   input  logic              PixValid,
   output logic              PixReady,
   input  logic              WE0,
   input  logic              WE1,
   input  logic              Buf0Empty,
   input  logic              Buf1Empty,
   output logic              Wr0,
   output logic              Wr1,
   output logic [ADDR_W-1:0] WrAddr,
   output logic [7:0]        WrData,
   output logic              Buf0Full,
   output logic              Buf1Full,
   output logic              BufSel,
   output logic              FrameDone
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ACCEPT = 3'd1;
   localparam logic [2:0] S_WR_R   = 3'd2;
   localparam logic [2:0] S_WR_G   = 3'd3;
   localparam logic [2:0] S_WR_B   = 3'd4;

   logic [2:0]        state_q, state_d;
   logic              sel_q, sel_d;
   logic [23:0]       pix_q, pix_d;
   logic [9:0]        col_q, col_d;
   logic [9:0]        row_q, row_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [9:0]        aip_q, aip_d;
   logic [9:0]        ail_q, ail_d;
   logic [1:0]        full_q, full_d;
   logic              done_q, done_d;

   logic              writable;
   logic              col_last;
   logic              last_pix;
   logic              writing;
   logic              ready;
   logic              hs;
   logic [ADDR_W-1:0] addr_inc;
   logic [7:0]        wr_byte;

   assign writable = sel_q ? (WE1 && !full_q[1])
                           : (WE0 && !full_q[0]);
   assign col_last = (col_q == aip_q - 10'd1);
   assign last_pix = col_last && (row_q == ail_q - 10'd1);
   assign writing  = (state_q == S_WR_R) ||
                     (state_q == S_WR_G) ||
                     (state_q == S_WR_B);
   assign addr_inc = addr_q + ADDR_W'(1);
   assign hs       = PixValid && ready;

   // The last B byte of a frame never overlaps a new handshake.
   always_comb begin
      ready = 1'b0;
      case (state_q)
         S_ACCEPT: ready = writable;
         S_WR_B:   ready = !last_pix && writable && CSDisplay;
         default:  ready = 1'b0;
      endcase
   end

   always_comb begin
      wr_byte = 8'h00;
      case (state_q)
         S_WR_R:  wr_byte = pix_q[23:16];
         S_WR_G:  wr_byte = pix_q[15:8];
         S_WR_B:  wr_byte = pix_q[7:0];
         default: wr_byte = 8'h00;
      endcase
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      pix_d   = pix_q;
      col_d   = col_q;
      row_d   = row_q;
      addr_d  = addr_q;
      aip_d   = aip_q;
      ail_d   = ail_q;
      done_d  = 1'b0;
      full_d  = full_q & ~{Buf1Empty, Buf0Empty};
      case (state_q)
         S_IDLE: begin
            if (CSDisplay && AIPIn != 10'd0 && AILIn != 10'd0) begin
               state_d = S_ACCEPT;
               aip_d   = AIPIn;
               ail_d   = AILIn;
               col_d   = '0;
               row_d   = '0;
               addr_d  = '0;
            end
         end
         S_ACCEPT: begin
            if (hs) begin
               pix_d   = PixIn;
               state_d = S_WR_R;
            end else if (!CSDisplay) begin
               state_d = S_IDLE;
               col_d   = '0;
               row_d   = '0;
               addr_d  = '0;
            end
         end
         S_WR_R: begin
            addr_d  = addr_inc;
            state_d = S_WR_G;
         end
         S_WR_G: begin
            addr_d  = addr_inc;
            state_d = S_WR_B;
         end
         S_WR_B: begin
            if (last_pix) begin
               // Setting the flag here overrides a same-cycle release.
               full_d[sel_q] = 1'b1;
               done_d  = 1'b1;
               sel_d   = ~sel_q;
               col_d   = '0;
               row_d   = '0;
               addr_d  = '0;
               aip_d   = AIPIn;
               ail_d   = AILIn;
               state_d = S_ACCEPT;
            end else begin
               addr_d = addr_inc;
               if (col_last) begin
                  col_d = '0;
                  row_d = row_q + 10'd1;
               end else begin
                  col_d = col_q + 10'd1;
               end
               if (hs) begin
                  pix_d   = PixIn;
                  state_d = S_WR_R;
               end else if (CSDisplay) begin
                  state_d = S_ACCEPT;
               end else begin
                  state_d = S_IDLE;
                  col_d   = '0;
                  row_d   = '0;
                  addr_d  = '0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         sel_q   <= 1'b0;
         pix_q   <= '0;
         col_q   <= '0;
         row_q   <= '0;
         addr_q  <= '0;
         aip_q   <= '0;
         ail_q   <= '0;
         full_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         pix_q   <= pix_d;
         col_q   <= col_d;
         row_q   <= row_d;
         addr_q  <= addr_d;
         aip_q   <= aip_d;
         ail_q   <= ail_d;
         full_q  <= full_d;
         done_q  <= done_d;
      end
   end

   assign PixReady  = ready;
   assign Wr0       = writing && !sel_q;
   assign Wr1       = writing && sel_q;
   assign WrAddr    = writing ? addr_q : '0;
   assign WrData    = wr_byte;
   assign Buf0Full  = full_q[0];
   assign Buf1Full  = full_q[1];
   assign BufSel    = sel_q;
   assign FrameDone = done_q;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Bench for frame_buffer_writer: directed scenarios plus random traffic,
// checked every cycle against a pixel-index model of the write stream.
module tb_frame_buffer_writer;

   logic        clk = 1'b0;
   logic        rst, cs, pv, we0, we1, e0, e1;
   logic [9:0]  aip, ail;
   logic [23:0] pix;
   logic        rdy, wr0, wr1, f0, f1, sel, done;
   logic [15:0] waddr;
   logic [7:0]  wdata;

   always #5 clk = ~clk;

   frame_buffer_writer #(.ADDR_W(16)) dut (
      .clk(clk), .reset(rst), .CSDisplay(cs),
      .AIPIn(aip), .AILIn(ail), .PixIn(pix),
      .PixValid(pv), .PixReady(rdy),
      .WE0(we0), .WE1(we1),
      .Buf0Empty(e0), .Buf1Empty(e1),
      .Wr0(wr0), .Wr1(wr1), .WrAddr(waddr), .WrData(wdata),
      .Buf0Full(f0), .Buf1Full(f1), .BufSel(sel), .FrameDone(done)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // model: phase 0 idle, 1 accept, 2/3/4 writing R/G/B of pixel m_idx
   int m_ph, m_sel, m_idx, m_n, m_pix, m_done, m_hs;
   int m_full[2];
   int e_rdy;

   int n_hs, n_done, n_wr0, n_wr1, fw_buf, fw_addr;
   int hs_q[$];
   logic [7:0] mem0 [12];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0h required=%0h",
                  nm, cyc, act, exp);
      end
   endtask

   task automatic mreset();
      m_ph = 0; m_sel = 0; m_idx = 0; m_n = 0;
      m_pix = 0; m_done = 0; m_hs = 0;
      m_full[0] = 0; m_full[1] = 0;
   endtask

   task automatic clr_stats();
      n_hs = 0; n_done = 0; n_wr0 = 0; n_wr1 = 0;
      fw_buf = -1; fw_addr = -1;
      hs_q.delete();
   endtask

   task automatic compare();
      int wr, w, ea, ed;
      if (rst) mreset();
      wr = (m_ph >= 2);
      w  = m_sel ? (we1 && !m_full[1]) : (we0 && !m_full[0]);
      if (m_ph == 1) e_rdy = w;
      else if (m_ph == 4 && m_idx != m_n - 1) e_rdy = w && cs;
      else e_rdy = 0;
      ea = wr ? m_idx * 3 + m_ph - 2 : 0;
      ed = wr ? (m_pix >> (8 * (4 - m_ph))) & 255 : 0;
      chk("PixReady", rdy, e_rdy);
      chk("Wr0", wr0, wr && m_sel == 0);
      chk("Wr1", wr1, wr && m_sel == 1);
      chk("WrAddr", waddr, ea);
      chk("WrData", wdata, ed);
      chk("Buf0Full", f0, m_full[0]);
      chk("Buf1Full", f1, m_full[1]);
      chk("BufSel", sel, m_sel);
      chk("FrameDone", done, m_done);
      if (rdy && pv) begin
         n_hs++;
         hs_q.push_back(cyc);
      end
      if (done) n_done++;
      if (wr0) begin
         n_wr0++;
         if (waddr < 12) mem0[waddr[3:0]] = wdata;
      end
      if (wr1) n_wr1++;
      if ((wr0 || wr1) && fw_buf < 0) begin
         fw_buf = wr1 ? 1 : 0;
         fw_addr = int'(waddr);
      end
   endtask

   task automatic update();
      cyc++;
      if (rst) begin
         mreset();
         return;
      end
      m_hs = pv && e_rdy;
      m_done = 0;
      if (e0) m_full[0] = 0;
      if (e1) m_full[1] = 0;
      case (m_ph)
         0: if (cs && aip != 0 && ail != 0) begin
               m_n = aip * ail; m_idx = 0; m_ph = 1;
            end
         1: if (m_hs) begin
               m_pix = pix; m_ph = 2;
            end else if (!cs) m_ph = 0;
         2: m_ph = 3;
         3: m_ph = 4;
         default: begin
            if (m_idx == m_n - 1) begin
               m_full[m_sel] = 1;
               m_done = 1;
               m_sel ^= 1;
               m_idx = 0;
               m_n = aip * ail;
               m_ph = 1;
            end else begin
               m_idx++;
               if (m_hs) begin
                  m_pix = pix; m_ph = 2;
               end else m_ph = cs ? 1 : 0;
            end
         end
      endcase
   endtask

   task automatic step();
      @(negedge clk);
      compare();
      @(posedge clk);
      update();
      #2;
   endtask

   initial begin
      int k;
      logic [23:0] px [4];
      px[0] = 24'h112233; px[1] = 24'h445566;
      px[2] = 24'h778899; px[3] = 24'hAABBCC;
      mreset();
      clr_stats();
      rst = 1; cs = 0; pv = 0; we0 = 0; we1 = 0;
      e0 = 0; e1 = 0; aip = 0; ail = 0; pix = 0;
      repeat (3) step();

      // basic frame into buffer 0
      rst = 0; cs = 1; aip = 2; ail = 2; we0 = 1; pv = 1;
      k = 0; pix = px[0];
      clr_stats();
      for (int i = 0; i < 40 && n_done == 0; i++) begin
         step();
         if (m_hs) k++;
         if (k >= 4) pv = 0;
         else pix = px[k];
      end
      repeat (3) step();
      chk("t1_done_count", n_done, 1);
      chk("t1_hs_count", n_hs, 4);
      for (int i = 0; i < 12; i++)
         chk("t1_byte", mem0[i], (i + 1) * 17);
      for (int i = 1; i < hs_q.size(); i++)
         chk("t1_hs_gap", hs_q[i] - hs_q[i-1], 3);
      chk("t1_buf0full", f0, 1);
      chk("t1_bufsel", sel, 1);
      chk("t1_no_wr1", n_wr1, 0);

      // buffer 1 blocked until its grant, then written from 0
      clr_stats();
      pv = 1; pix = $urandom;
      repeat (10) step();
      chk("t2_blocked_hs", n_hs, 0);
      we1 = 1;
      for (int i = 0; i < 60 && n_done == 0; i++) begin
         e1 = (m_ph == 4 && m_idx == m_n - 1);
         step();
         pix = $urandom;
      end
      e1 = 0;
      chk("t2_first_buf", fw_buf, 1);
      chk("t2_first_addr", fw_addr, 0);
      chk("t2_wr1_count", n_wr1, 12);
      chk("t2_wr0_count", n_wr0, 0);
      chk("t2_buf1full_setwins", f1, 1);
      chk("t2_buf0full", f0, 1);
      chk("t2_bufsel", sel, 0);

      // both full: blocked until buffer 0 is released
      clr_stats();
      repeat (10) step();
      chk("t3_blocked_hs", n_hs, 0);
      e0 = 1;
      step();
      e0 = 0;
      chk("t3_buf0_cleared", f0, 0);
      for (int i = 0; i < 10 && fw_buf < 0; i++) step();
      chk("t3_first_buf", fw_buf, 0);
      chk("t3_first_addr", fw_addr, 0);

      // host stall holds address, disable restarts the frame
      pv = 0;
      for (int i = 0; i < 10 && m_ph != 1; i++) step();
      repeat (5) step();
      clr_stats();
      pv = 1;
      for (int i = 0; i < 10 && fw_buf < 0; i++) step();
      chk("t4_stall_addr", fw_addr, 3);
      pv = 0;
      for (int i = 0; i < 10 && m_ph != 1; i++) step();
      cs = 0;
      repeat (2) step();
      chk("t4_idle_ready", rdy, 0);
      cs = 1; pv = 1;
      clr_stats();
      for (int i = 0; i < 10 && fw_buf < 0; i++) step();
      chk("t4_restart_buf", fw_buf, 0);
      chk("t4_restart_addr", fw_addr, 0);

      // reset during WR_G, then zero size keeps it idle
      for (int i = 0; i < 10 && m_ph != 3; i++) step();
      rst = 1; aip = 0;
      step();
      clr_stats();
      rst = 0;
      repeat (10) step();
      chk("t5_no_writes", n_wr0 + n_wr1, 0);
      chk("t5_no_hs", n_hs, 0);
      chk("t5_sel", sel, 0);
      chk("t5_full", {f1, f0}, 0);

      // random traffic
      aip = 2; ail = 2;
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 999) < 3);
         cs  = ($urandom_range(0, 99) < 95);
         pv  = ($urandom_range(0, 99) < 70);
         we0 = ($urandom_range(0, 99) < 85);
         we1 = ($urandom_range(0, 99) < 85);
         e0  = ($urandom_range(0, 99) < 6);
         e1  = ($urandom_range(0, 99) < 6);
         pix = $urandom;
         if ($urandom_range(0, 9) == 0) begin
            aip = 10'($urandom_range(1, 4));
            ail = 10'($urandom_range(1, 3));
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
